ks_adder_pipe: RTL and testbench

//   Parametrised, pipelined Kogge-Stone adder: S = A + B + in_C, with carry-out.

---
 rtl/ks_adder_pipe.sv | 165 ++++++++++++++++
 tb/tb_ks_adder_pipe.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_adder_pipe.sv
// ks_adder_pipe: pipelined Kogge-Stone adder, {out_C,S} = A + B + in_C, valid/ready on both sides.
// Define KSA_OVF_EN to add the registered signed-overflow output out_ovf.
module ks_adder_pipe #(
    parameter int WIDTH       = 16,
    parameter int PIPE_LEVELS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_C,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
`ifdef KSA_OVF_EN
    output logic             out_C,
    output logic             out_ovf
`else
    output logic             out_C
`endif
);

    localparam int LOG = $clog2(WIDTH);

    // Handshake: a transfer happens on valid & ready at a rising edge. The whole pipe
    // moves as one shift register (bubbles included) whenever the output slot is free
    // or being consumed; otherwise every stage holds, so in_ready mirrors advance.
    logic advance;
    logic out_valid_q;

    assign advance   = !out_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;

    // Stage 0: bitwise generate/propagate; carry-in is merged into bit 0's generate,
    // which is equivalent to treating it as the generate of position -1.
    logic [WIDTH-1:0] s0_g_d, s0_g_q, s0_p_q;
    logic             s0_c_q, s0_v_q;

    always_comb begin
        s0_g_d    = A & B;
        s0_g_d[0] = (A[0] & B[0]) | ((A[0] ^ B[0]) & in_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_g_q <= '0;
            s0_p_q <= '0;
            s0_c_q <= 1'b0;
            s0_v_q <= 1'b0;
        end else if (advance) begin
            s0_g_q <= s0_g_d;
            s0_p_q <= A ^ B;
            s0_c_q <= in_C;
            s0_v_q <= in_valid;
        end
    end

    for (genvar k = 0; k < LOG; k++) begin : g_lvl
        localparam int D = 1 << k;

        logic [WIDTH-1:0] g_in, p_in, r_in, g_d, p_d, g_o, p_o, r_o;
        logic             c_in, v_in, c_o, v_o;

        if (k == 0) begin : g_src
            assign g_in = s0_g_q;
            assign p_in = s0_p_q;
            assign r_in = s0_p_q;
            assign c_in = s0_c_q;
            assign v_in = s0_v_q;
        end else begin : g_src
            assign g_in = g_lvl[k-1].g_o;
            assign p_in = g_lvl[k-1].p_o;
            assign r_in = g_lvl[k-1].r_o;
            assign c_in = g_lvl[k-1].c_o;
            assign v_in = g_lvl[k-1].v_o;
        end

        // Prefix operator at distance D; the low D positions are already complete.
        always_comb begin
            g_d = g_in;
            p_d = p_in;
            for (int i = D; i < WIDTH; i++) begin
                g_d[i] = g_in[i] | (p_in[i] & g_in[i-D]);
                p_d[i] = p_in[i] & p_in[i-D];
            end
        end

        if (PIPE_LEVELS != 0) begin : g_reg
            logic [WIDTH-1:0] g_q, p_q, r_q;
            logic             c_q, v_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    g_q <= '0;
                    p_q <= '0;
                    r_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (advance) begin
                    g_q <= g_d;
                    p_q <= p_d;
                    r_q <= r_in;
                    c_q <= c_in;
                    v_q <= v_in;
                end
            end

            assign g_o = g_q;
            assign p_o = p_q;
            assign r_o = r_q;
            assign c_o = c_q;
            assign v_o = v_q;
        end else begin : g_wire
            assign g_o = g_d;
            assign p_o = p_d;
            assign r_o = r_in;
            assign c_o = c_in;
            assign v_o = v_in;
        end
    end

    // gc[i] is the carry out of bit i with in_C already included.
    logic [WIDTH-1:0] gc, pr, s_d, s_q;
    logic             cf, vf, out_c_q, unused_p;

    assign gc       = g_lvl[LOG-1].g_o;
    assign pr       = g_lvl[LOG-1].r_o;
    assign cf       = g_lvl[LOG-1].c_o;
    assign vf       = g_lvl[LOG-1].v_o;
    assign unused_p = ^g_lvl[LOG-1].p_o;
    assign s_d      = pr ^ {gc[WIDTH-2:0], cf};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= '0;
            out_c_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (advance) begin
            s_q         <= s_d;
            out_c_q     <= gc[WIDTH-1];
            out_valid_q <= vf;
        end
    end

    assign S     = s_q;
    assign out_C = out_c_q;

`ifdef KSA_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= gc[WIDTH-2] ^ gc[WIDTH-1];
        end
    end

    assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Self-checking bench for ks_adder_pipe: arithmetic model + scoreboard, directed vectors,
// stall/reset scenarios, and a second instance with a combinational prefix tree.
module tb_ks_adder_pipe;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // pipelined instance
    logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, cin = 1'b0, out_c;
    logic [W-1:0] a = '0, b = '0, s;
    // combinational-tree instance
    logic         in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b1, cin0 = 1'b0, out_c0;
    logic [W-1:0] a0 = '0, b0 = '0, s0;
`ifdef KSA_OVF_EN
    logic out_ovf, out_ovf0;
`endif

    ks_adder_pipe #(.WIDTH(W), .PIPE_LEVELS(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .in_C(cin), .out_valid(out_valid), .out_ready(out_ready),
`ifdef KSA_OVF_EN
        .S(s), .out_C(out_c), .out_ovf(out_ovf)
`else
        .S(s), .out_C(out_c)
`endif
    );

    ks_adder_pipe #(.WIDTH(W), .PIPE_LEVELS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .A(a0), .B(b0), .in_C(cin0), .out_valid(out_valid0), .out_ready(out_ready0),
`ifdef KSA_OVF_EN
        .S(s0), .out_C(out_c0), .out_ovf(out_ovf0)
`else
        .S(s0), .out_C(out_c0)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: {ovf, carry, sum} from plain unsigned and signed integer addition.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        logic [W:0] u;
        longint     sa;
        longint     smax;
        logic       ovf;
        u    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        sa   = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        smax = (longint'(1) <<< (W - 1)) - 1;
        ovf  = (sa > smax) || (sa < -smax - 1);
        return {ovf, u};
    endfunction

    function automatic logic [63:0] fold(input logic [W+1:0] e);
`ifdef KSA_OVF_EN
        return 64'(e);
`else
        return 64'(e[W:0]);
`endif
    endfunction

    function automatic logic [63:0] act1();
`ifdef KSA_OVF_EN
        return 64'({out_ovf, out_c, s});
`else
        return 64'({out_c, s});
`endif
    endfunction

    function automatic logic [63:0] act0();
`ifdef KSA_OVF_EN
        return 64'({out_ovf0, out_c0, s0});
`else
        return 64'({out_c0, s0});
`endif
    endfunction

    // Scoreboard
    logic [W+1:0] exp_q[$];
    logic [W+1:0] exp0_q[$];
    logic         hold_vld = 1'b0;
    logic [63:0]  hold_val = '0;
    int           out_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_vld = 1'b0;
        end else begin
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin));
            if (hold_vld) begin
                chk("stall_hold_valid", 64'(out_valid), 64'(1));
                chk("stall_hold_data", act1(), hold_val);
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got %0h expected no result (t=%0t)", act1(), $time);
                end else begin
                    chk("result", act1(), fold(exp_q.pop_front()));
                end
            end
            hold_vld = out_valid && !out_ready;
            hold_val = act1();

            if (in_valid0 && in_ready0) exp0_q.push_back(model(a0, b0, cin0));
            if (out_valid0 && out_ready0) begin
                if (exp0_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out0: got %0h expected no result (t=%0t)", act0(), $time);
                end else begin
                    chk("result0", act0(), fold(exp0_q.pop_front()));
                end
            end
        end
    end

    bit rand_rdy = 1'b0;
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Drives one operand set and holds it until accepted; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        bit acc;
        acc      = 1'b0;
        a        = x;
        b        = y;
        cin      = c;
        in_valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 64'(acc), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts edges from the accepting edge (=1) until out_valid is seen.
    task automatic measure_lat(input bit which0, output int k);
        k = 1;
        while (!(which0 ? out_valid0 : out_valid) && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         c;
        logic [W+1:0] e;
    } vec_t;

    vec_t vecs[8];
    int   lat;
    int   c_start;

    initial begin
        vecs[0] = '{16'h0000, 16'h0000, 1'b1, {1'b0, 1'b0, 16'h0001}};
        vecs[1] = '{16'h00FF, 16'h0001, 1'b0, {1'b0, 1'b0, 16'h0100}};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, {1'b0, 1'b1, 16'h0000}};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b0, {1'b0, 1'b1, 16'hFFFE}};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, {1'b0, 1'b1, 16'hFFFF}};
        vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h8000}};
        vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, {1'b1, 1'b1, 16'h7FFF}};
        vecs[7] = '{16'h1234, 16'h4321, 1'b0, {1'b0, 1'b0, 16'h5555}};

        // Reset state
        idle(3);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_sum", act1(), 64'(0));
        chk("rst_out_valid0", 64'(out_valid0), 64'(0));
        chk("rst_sum0", act0(), 64'(0));
        rst_n = 1'b1;
        idle(2);

        foreach (vecs[i]) chk("model_pin", 64'(model(vecs[i].x, vecs[i].y, vecs[i].c)), 64'(vecs[i].e));

        // First result latency and value
        send(16'h0000, 16'h0000, 1'b1);
        measure_lat(1'b0, lat);
        chk("latency_pipe", 64'(lat), 64'($clog2(W) + 2));
        chk("t1_sum", 64'(s), 64'(16'h0001));
        chk("t1_carry", 64'(out_c), 64'(0));
        idle(2);

        // Directed vectors back-to-back: one acceptance per cycle, one result per cycle
        c_start = cyc;
        out_cnt = 0;
        foreach (vecs[i]) send(vecs[i].x, vecs[i].y, vecs[i].c);
        chk("stream_accept_cycles", 64'(cyc - c_start), 64'(8));
        idle(10);
        chk("stream_out_count", 64'(out_cnt), 64'(8));
        chk("stream_drained", 64'(exp_q.size()), 64'(0));

        // Backpressure with a full pipeline and a pending operand held by the producer
        for (int i = 0; i < 10; i++) send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        out_ready = 1'b0;
        fork
            send(16'hA5A5, 16'h5A5A, 1'b1);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", 64'(in_ready), 64'(0));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(12);
        chk("stall_drained", 64'(exp_q.size()), 64'(0));

        // Bubbles and random consumer backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        idle(14);
        chk("random_drained", 64'(exp_q.size()), 64'(0));

        // Reset with three operations in flight
        send(16'h1111, 16'h2222, 1'b0);
        send(16'h3333, 16'h4444, 1'b1);
        send(16'hFFFF, 16'h0001, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("midrst_no_out", 64'(out_valid), 64'(0));
            idle(1);
        end
        send(16'h00FF, 16'h0001, 1'b0);
        measure_lat(1'b0, lat);
        chk("latency_after_rst", 64'(lat), 64'($clog2(W) + 2));
        chk("after_rst_sum", 64'(s), 64'(16'h0100));
        idle(3);

        // Combinational prefix tree instance
        @(negedge clk);
        chk("comb_in_ready", 64'(in_ready0), 64'(1));
        @(posedge clk);
        #1;
        a0 = 16'h0000;
        b0 = 16'h0000;
        cin0 = 1'b1;
        in_valid0 = 1'b1;
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        measure_lat(1'b1, lat);
        chk("latency_comb", 64'(lat), 64'(2));
        chk("comb_t1_sum", 64'(s0), 64'(16'h0001));
        foreach (vecs[i]) begin
            a0 = vecs[i].x;
            b0 = vecs[i].y;
            cin0 = vecs[i].c;
            in_valid0 = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid0 = 1'b0;
        idle(5);
        chk("comb_drained", 64'(exp0_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
